// File: rtl/prbs4_pkg.sv
// Shared definitions for the PRBS4 checker: checker states and the LFSR
// width and tap positions of the x^4 + x^3 + 1 reference sequence.
package prbs4_pkg;

    localparam int LFSR_W = 4;
    localparam int TAP_A  = 3;
    localparam int TAP_B  = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs4_predict.sv
// Next-bit predictor: hist[0] holds the newest bit, so b[k-n] sits at hist[n-1].
module prbs4_predict
    import prbs4_pkg::*;
(
    input  logic [LFSR_W-1:0] hist,
    output logic              pred
);

    assign pred = hist[TAP_A-1] ^ hist[TAP_B-1];

endmodule

// File: rtl/prbs4_checker.sv
// PRBS4 sequence checker: acquires the b[k] = b[k-3] ^ b[k-4] stream, then
// free-runs its own history and counts bit errors while locked.
//
// state  | meaning
// HUNT   | filling history with the first four received bits
// VERIFY | counting consecutive correct predictions towards lock
// LOCKED | history self-generated; mismatches are counted errors
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int FW = $clog2(LFSR_W);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_THR + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(LFSR_W - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THR - 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   hist_q, hist_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [MW-1:0]       match_q, match_d;
    logic [LW-1:0]       miss_q, miss_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0]    err_base;
    logic                pred;
    logic                mismatch;

    prbs4_predict u_predict (
        .hist (hist_q),
        .pred (pred)
    );

    assign mismatch = in_bit ^ pred;

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_base  = clr_err ? '0 : err_cnt_q;
        err_cnt_d = err_base;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    hist_d = {hist_q[LFSR_W-2:0], in_bit};
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    hist_d = {hist_q[LFSR_W-2:0], in_bit};
                    // All-zero history is the LFSR lock-up state and can never prove sync
                    if (!mismatch && (hist_q != '0)) begin
                        if (match_q == MATCH_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                            miss_d   = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    hist_d = {hist_q[LFSR_W-2:0], pred};
                    if (mismatch) begin
                        err_d     = 1'b1;
                        err_cnt_d = (&err_base) ? err_base : err_base + 1'b1;
                        if (miss_q == MISS_LAST) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            fill_d   = '0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                    fill_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= HUNT;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Randomized and directed bench for prbs4_checker against a queue-based
// model of acquisition, free-running reference and error counting.
module tb_prbs4_checker;

    localparam int EW       = 4;
    localparam int LOCK_CNT = 8;
    localparam int LOSS_THR = 4;
    localparam int CNT_MAX  = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_bit;
    logic          clr_err;
    logic          locked;
    logic          err;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    bit seq [15];
    int pos = 0;

    int m_locked = 0;
    int m_err    = 0;
    int m_cnt    = 0;
    int m_miss   = 0;
    bit acq  [$];
    bit refh [$];

    prbs4_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_THR (LOSS_THR),
        .ERR_W    (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_err   (clr_err),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 0;
        m_err    = 0;
        m_cnt    = 0;
        m_miss   = 0;
        acq.delete();
        refh.delete();
    endfunction

    // Lock when the trailing run of recurrence-consistent bits (after the
    // first four, with a non-zero window) reaches LOCK_CNT.
    function automatic void model_step(input logic v, input logic b, input logic c);
        int run;
        bit e;
        m_err = 0;
        if (c) m_cnt = 0;
        if (!v) return;
        if (m_locked == 0) begin
            acq.push_back(b);
            run = 0;
            for (int k = acq.size() - 1; k >= 4; k--) begin
                if ((acq[k] == (acq[k-3] ^ acq[k-4])) &&
                    ({acq[k-4], acq[k-3], acq[k-2], acq[k-1]} != 4'b0000))
                    run++;
                else
                    break;
            end
            if (run >= LOCK_CNT) begin
                m_locked = 1;
                m_miss   = 0;
                refh.delete();
                for (int i = acq.size() - 4; i < acq.size(); i++) refh.push_back(acq[i]);
                acq.delete();
            end
        end else begin
            e = refh[1] ^ refh[0];
            void'(refh.pop_front());
            refh.push_back(e);
            if (b != e) begin
                m_err = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
                m_miss++;
                if (m_miss == LOSS_THR) begin
                    m_locked = 0;
                    m_miss   = 0;
                    acq.delete();
                end
            end else begin
                m_miss = 0;
            end
        end
    endfunction

    task automatic step(input logic v, input logic b, input logic c);
        in_valid = v;
        in_bit   = b;
        clr_err  = c;
        @(posedge clk);
        model_step(v, b, c);
        #1;
        chk("locked", {31'd0, locked}, m_locked);
        chk("err", {31'd0, err}, m_err);
        chk("err_count", {28'd0, err_count}, m_cnt);
    endtask

    task automatic send(input logic flip, input logic c);
        step(1'b1, seq[pos] ^ flip, c);
        pos = (pos + 1) % 15;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_count", {28'd0, err_count}, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic v, f, c;
        seq[0] = 0; seq[1] = 0; seq[2] = 0; seq[3] = 1;
        for (int k = 4; k < 15; k++) seq[k] = seq[k-3] ^ seq[k-4];
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr_err  = 1'b0;
        do_reset();

        // Seed-1000 stream: lock on the 12th valid bit, no errors over 100 bits
        clean(11);
        chk("no_lock_at_11", {31'd0, locked}, 0);
        clean(1);
        chk("lock_at_12", {31'd0, locked}, 1);
        clean(88);
        chk("clean_100_err_count", {28'd0, err_count}, 0);

        // Single flipped bit
        send(1'b1, 1'b0);
        chk("single_err_pulse", {31'd0, err}, 1);
        clean(1);
        chk("single_err_drop", {31'd0, err}, 0);
        clean(2);
        chk("single_err_count", {28'd0, err_count}, 1);
        chk("single_still_locked", {31'd0, locked}, 1);

        // Four consecutive flips force loss, then relock
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
        chk("burst_err_count", {28'd0, err_count}, 4);
        chk("burst_unlocked", {31'd0, locked}, 0);
        clean(11);
        chk("relock_not_yet", {31'd0, locked}, 0);
        clean(1);
        chk("relock_at_12", {31'd0, locked}, 1);

        // clr_err coincident with a counted mismatch, then idle cycles
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0);
            clean(5);
        end
        chk("five_errs", {28'd0, err_count}, 5);
        send(1'b1, 1'b1);
        chk("clr_with_err", {28'd0, err_count}, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("idle_locked", {31'd0, locked}, 1);
        chk("idle_err_count", {28'd0, err_count}, 1);
        clean(5);

        // Mid-stream async reset needs full reacquisition
        do_reset();
        clean(11);
        chk("post_rst_not_locked", {31'd0, locked}, 0);
        clean(1);
        chk("post_rst_lock_12", {31'd0, locked}, 1);

        // All-zero stream never locks
        do_reset();
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);
        chk("zeros_unlocked", {31'd0, locked}, 0);
        chk("zeros_err_count", {28'd0, err_count}, 0);

        // Randomized: gaps, sparse flips, rare clears; reaches saturation
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 299) == 0);
            if (v) send(f, c);
            else step(1'b0, 1'($urandom_range(0, 1)), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs4_checker.md
PRBS4_CHECKER -- requirements
Module: prbs4_checker

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive correct predictions required to declare lock.
REQ-002 Parameter LOSS_THR, default 4: consecutive mismatches while locked that force loss of lock.
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bit is sampled this cycle when high.
REQ-007 in_bit  input  1  received serial bit, the state[0] stream of the team's 4-bit LFSR generator.
REQ-008 clr_err  input  1  synchronous clear of err_count.
REQ-009 locked  output  1  checker is synchronised to the sequence.
REQ-010 err  output  1  one-cycle pulse per counted bit error.
REQ-011 err_count  output  ERR_W  saturating count of bit errors seen while locked.

Function
REQ-012 Reference sequence SHALL be b[k] = b[k-3] XOR b[k-4] (period 15; seed 1000 gives 000100110101111).
REQ-013 Only cycles with in_valid=1 SHALL advance history, counters or FSM; with in_valid=0 all state holds and err=0.
REQ-014 A 4-bit history SHALL hold the last four bits; predicted bit = hist[k-3] XOR hist[k-4].
REQ-015 FSM states HUNT, VERIFY and LOCKED SHALL exist; reset state HUNT.
REQ-016 HUNT: shift in_bit into history; after the 4th valid bit, go to VERIFY with match count 0.
REQ-017 VERIFY: shift in_bit into history; a match with non-zero history increments the match count; a mismatch or all-zero history clears it.
REQ-018 VERIFY: the valid bit that brings the match count to LOCK_CNT SHALL set locked=1 and enter LOCKED on the same edge.
REQ-019 LOCKED: history SHALL be fed the predicted bit, not in_bit, so a single flipped bit yields exactly one error.
REQ-020 LOCKED: a mismatch SHALL raise err on the next cycle and increment err_count, saturating at all-ones.
REQ-021 LOCKED: LOSS_THR consecutive mismatches SHALL clear locked, clear the fill count and enter HUNT on the edge sampling the last mismatch; any match clears the mismatch count.
REQ-022 Mismatches outside LOCKED SHALL NOT assert err or change err_count.
REQ-023 clr_err SHALL zero err_count; if a counted mismatch occurs on the same edge, err_count SHALL become 1.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst=0 SHALL immediately, without a clock, force FSM=HUNT, history=0000, fill, match and mismatch counts=0, locked=0, err=0, err_count=0.
REQ-026 After rst is released, operation SHALL resume from HUNT on the first valid bit; a mid-stream reset requires full reacquisition.

Structure
REQ-027 Package prbs4_pkg SHALL hold the FSM state enum, the LFSR width (4) and the tap positions (3, 4).
REQ-028 One sub-module, prbs4_predict (combinational: 4-bit history in, predicted bit out), SHALL be used.

Verification
REQ-029 Reset, then seed-1000 stream with continuous valid: locked rises on the edge sampling bit 12; err_count=0 after 100 bits.
REQ-030 After lock, invert one bit: exactly one err pulse, err_count=1, locked stays 1.
REQ-031 After lock, invert 4 consecutive bits: err_count=4 and locked=0 after the 4th; a clean stream relocks 12 valid bits later.
REQ-032 All-zero stream for 50 bits: locked stays 0 and err_count stays 0.
REQ-033 Locked with err_count=5, assert clr_err on the same edge as a mismatch: err_count=1. Then in_valid low for 10 cycles: no state change.
REQ-034 Pulse rst low mid-stream, between clock edges: all outputs are 0 before the next edge; relock occurs after 12 further valid bits.
